// File: rtl/cpu_pkg.sv
// Shared constants for the control unit: opcodes, bus/enable bit positions,
// ALU codes, FSM state encodings and the instruction-class enumeration.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int ENC_ZLOW = 19;
  localparam int ENC_PC   = 20;
  localparam int ENC_MDR  = 22;
  localparam int ENC_C    = 25;

  localparam int EN_ZLOW = 19;
  localparam int EN_PC   = 20;
  localparam int EN_IR   = 21;
  localparam int EN_MDR  = 22;
  localparam int EN_MAR  = 23;
  localparam int EN_Y    = 24;

  localparam logic [5:0] ALU_ADD = 6'd3;
  localparam logic [5:0] ALU_SUB = 6'd4;
  localparam logic [5:0] ALU_AND = 6'd5;
  localparam logic [5:0] ALU_OR  = 6'd6;

  localparam logic [3:0] S_RST  = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_T7   = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;

  typedef enum logic [2:0] {
    IC_RTYPE,
    IC_ITYPE,
    IC_LD,
    IC_ST,
    IC_NOP,
    IC_HALT
  } inst_class_t;

  // Immediate forms reuse the ALU code of their register counterpart.
  function automatic logic [5:0] alu_code(input logic [4:0] op);
    case (op)
      OP_ADDI: alu_code = ALU_ADD;
      OP_ANDI: alu_code = ALU_AND;
      OP_ORI:  alu_code = ALU_OR;
      default: alu_code = {1'b0, op};
    endcase
  endfunction

endpackage

// File: rtl/ir_decoder.sv
// Maps an opcode to its instruction class; unknown opcodes behave as NOP.
module ir_decoder
  import cpu_pkg::*;
(
  input  logic [4:0]  opcode,
  output inst_class_t inst_class
);

  always_comb begin
    inst_class = IC_NOP;
    case (opcode)
      OP_LD:                           inst_class = IC_LD;
      OP_ST:                           inst_class = IC_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR:   inst_class = IC_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:        inst_class = IC_ITYPE;
      OP_HALT:                         inst_class = IC_HALT;
      default:                         inst_class = IC_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Microsequencer for the simple CPU: fetch in T0..T2, execute in T3..T7,
// control outputs decoded from the current step and the instruction register.
//
// state | meaning
// RST   | held in reset, all outputs low
// T0    | PC -> MAR, increment PC
// T1    | memory -> MDR
// T2    | MDR -> IR
// T3    | first execute step (operand B / base into Y)
// T4    | ALU operation into Zlow
// T5    | Zlow -> Ra (R/I) or Zlow -> MAR (LD/ST)
// T6    | memory access setup (LD/ST)
// T7    | load writeback or memory write
// HALT  | stopped until reset
module control_unit
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        clr,
  input  logic [31:0] IR,
  output logic [31:0] enc_input,
  output logic [31:0] reg_enable,
  output logic        read,
  output logic        write,
  output logic        incPC,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [3:0]  Gra,
  output logic [3:0]  Grb,
  output logic [3:0]  Grc,
  output logic [5:0]  ALU_Sel,
  output logic        run
);

  logic [3:0]  state;
  logic [3:0]  state_nxt;
  inst_class_t inst_class;
  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        is_mem;
  logic        unused_ir_bits;

  assign opcode         = IR[31:27];
  assign ra             = IR[26:23];
  assign rb             = IR[22:19];
  assign rc             = IR[18:15];
  assign unused_ir_bits = ^IR[14:0];
  assign is_mem         = (inst_class == IC_LD) || (inst_class == IC_ST);

  ir_decoder u_ir_decoder (
    .opcode     (opcode),
    .inst_class (inst_class)
  );

  always_ff @(posedge clock or negedge clr) begin
    if (!clr) state <= S_RST;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RST: state_nxt = S_T0;
      S_T0:  state_nxt = S_T1;
      S_T1:  state_nxt = S_T2;
      S_T2:  state_nxt = S_T3;
      S_T3: begin
        if (inst_class == IC_HALT)     state_nxt = S_HALT;
        else if (inst_class == IC_NOP) state_nxt = S_T0;
        else                           state_nxt = S_T4;
      end
      S_T4:   state_nxt = S_T5;
      S_T5:   state_nxt = is_mem ? S_T6 : S_T0;
      S_T6:   state_nxt = S_T7;
      S_T7:   state_nxt = S_T0;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_RST;
    endcase
  end

  assign run = (state != S_RST) && (state != S_HALT);

  always_comb begin
    enc_input  = '0;
    reg_enable = '0;
    read       = 1'b0;
    write      = 1'b0;
    incPC      = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    BAout      = 1'b0;
    Gra        = '0;
    Grb        = '0;
    Grc        = '0;
    ALU_Sel    = '0;
    case (state)
      S_T0: begin
        enc_input[ENC_PC]  = 1'b1;
        reg_enable[EN_MAR] = 1'b1;
        incPC              = 1'b1;
      end
      S_T1: begin
        read               = 1'b1;
        reg_enable[EN_MDR] = 1'b1;
      end
      S_T2: begin
        enc_input[ENC_MDR] = 1'b1;
        reg_enable[EN_IR]  = 1'b1;
      end
      S_T3: begin
        if (inst_class != IC_NOP && inst_class != IC_HALT) begin
          Grb              = rb;
          reg_enable[EN_Y] = 1'b1;
          if (is_mem) BAout = 1'b1;
          else        Rout  = 1'b1;
        end
      end
      S_T4: begin
        reg_enable[EN_ZLOW] = 1'b1;
        if (inst_class == IC_RTYPE) begin
          Grc     = rc;
          Rout    = 1'b1;
          ALU_Sel = alu_code(opcode);
        end else begin
          enc_input[ENC_C] = 1'b1;
          ALU_Sel          = is_mem ? ALU_ADD : alu_code(opcode);
        end
      end
      S_T5: begin
        enc_input[ENC_ZLOW] = 1'b1;
        if (is_mem) begin
          reg_enable[EN_MAR] = 1'b1;
        end else begin
          Gra = ra;
          Rin = 1'b1;
        end
      end
      S_T6: begin
        reg_enable[EN_MDR] = 1'b1;
        if (inst_class == IC_LD) begin
          read = 1'b1;
        end else begin
          Gra  = ra;
          Rout = 1'b1;
        end
      end
      S_T7: begin
        if (inst_class == IC_LD) begin
          enc_input[ENC_MDR] = 1'b1;
          Gra                = ra;
          Rin                = 1'b1;
        end else begin
          write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized instruction stream checked step-by-step against a table-driven
// model of the expected control word for every step of every instruction.
module tb_control_unit;

  typedef struct packed {
    logic [31:0] enc;
    logic [31:0] en;
    logic        read;
    logic        write;
    logic        inc_pc;
    logic        rin;
    logic        rout;
    logic        ba_out;
    logic [3:0]  gra;
    logic [3:0]  grb;
    logic [3:0]  grc;
    logic [5:0]  alu;
    logic        run;
  } out_t;

  logic        clock = 1'b0;
  logic        clr   = 1'b0;
  logic [31:0] IR    = 32'h0;
  logic [31:0] enc_input, reg_enable;
  logic        read, write, incPC, Rin, Rout, BAout, run;
  logic [3:0]  Gra, Grb, Grc;
  logic [5:0]  ALU_Sel;
  out_t        obs;

  int checks   = 0;
  int failures = 0;
  out_t exp_q[$];

  control_unit dut (
    .clock      (clock),
    .clr        (clr),
    .IR         (IR),
    .enc_input  (enc_input),
    .reg_enable (reg_enable),
    .read       (read),
    .write      (write),
    .incPC      (incPC),
    .Rin        (Rin),
    .Rout       (Rout),
    .BAout      (BAout),
    .Gra        (Gra),
    .Grb        (Grb),
    .Grc        (Grc),
    .ALU_Sel    (ALU_Sel),
    .run        (run)
  );

  always #5 clock = ~clock;

  assign obs = {enc_input, reg_enable, read, write, incPC, Rin, Rout, BAout,
                Gra, Grb, Grc, ALU_Sel, run};

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  always @(negedge clock) chk("enc_onehot", ($countones(enc_input) <= 1), 1'b1);

  function automatic out_t active();
    out_t r;
    r     = '0;
    r.run = 1'b1;
    return r;
  endfunction

  // Expected control words for one instruction, listed in execution order.
  task automatic build(input logic [31:0] ir);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    int         cls;  // 0 R, 1 I, 2 LD, 3 ST, 4 NOP, 5 HALT
    logic [5:0] alu;
    out_t       r;
    op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    case (op)
      5'd0:                  cls = 2;
      5'd2:                  cls = 3;
      5'd3, 5'd4, 5'd5, 5'd6: cls = 0;
      5'd12, 5'd13, 5'd14:   cls = 1;
      5'd27:                 cls = 5;
      default:               cls = 4;
    endcase
    case (op)
      5'd12:   alu = 6'd3;
      5'd13:   alu = 6'd5;
      5'd14:   alu = 6'd6;
      default: alu = {1'b0, op};
    endcase
    exp_q.delete();
    r = active(); r.enc[20] = 1; r.en[23] = 1; r.inc_pc = 1; exp_q.push_back(r);
    r = active(); r.read = 1; r.en[22] = 1;                   exp_q.push_back(r);
    r = active(); r.enc[22] = 1; r.en[21] = 1;                exp_q.push_back(r);
    if (cls <= 1) begin
      r = active(); r.grb = rb; r.rout = 1; r.en[24] = 1; exp_q.push_back(r);
      r = active(); r.alu = alu; r.en[19] = 1;
      if (cls == 0) begin r.grc = rc; r.rout = 1; end
      else r.enc[25] = 1;
      exp_q.push_back(r);
      r = active(); r.enc[19] = 1; r.gra = ra; r.rin = 1; exp_q.push_back(r);
    end else if (cls <= 3) begin
      r = active(); r.grb = rb; r.ba_out = 1; r.en[24] = 1;  exp_q.push_back(r);
      r = active(); r.enc[25] = 1; r.alu = 6'd3; r.en[19] = 1; exp_q.push_back(r);
      r = active(); r.enc[19] = 1; r.en[23] = 1;              exp_q.push_back(r);
      r = active(); r.en[22] = 1;
      if (cls == 2) r.read = 1;
      else begin r.gra = ra; r.rout = 1; end
      exp_q.push_back(r);
      r = active();
      if (cls == 2) begin r.enc[22] = 1; r.gra = ra; r.rin = 1; end
      else r.write = 1;
      exp_q.push_back(r);
    end else begin
      exp_q.push_back(active());
      if (cls == 5) repeat (20) exp_q.push_back('0);
    end
  endtask

  // Garbage on IR during fetch; the real word appears only once T2 has been checked.
  task automatic run_instr(input logic [31:0] ir, input int abort_step);
    build(ir);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clock); #1;
      chk($sformatf("ir%h_step%0d", ir, k), obs, exp_q[k]);
      if (k == abort_step) begin
        #2 clr = 1'b0;
        #1 chk("clr_async_zero", obs, 128'h0);
        #1 clr = 1'b1;
        return;
      end
      if (k < 2) IR = $urandom;
      else if (k == 2) IR = ir;
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op);
    logic [31:0] w;
    w = $urandom;
    w[31:27] = op;
    return w;
  endfunction

  initial begin
    logic [4:0] op;
    IR = $urandom;
    #12 chk("reset_zero", obs, 128'h0);
    repeat (3) @(posedge clock);
    #1 chk("reset_hold", obs, 128'h0);
    @(negedge clock) clr = 1'b1;

    run_instr(32'h19A28000, -1);
    run_instr({5'b01100, 4'd2, 4'd1, 19'h0}, -1);
    run_instr(mk(5'b00000), -1);
    run_instr(mk(5'b00010), -1);
    run_instr(mk(5'b11010), -1);
    run_instr(mk(5'b11111), -1);
    run_instr(32'h19A28000, 4);
    run_instr(32'h19A28000, -1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 10))
        0: op = 5'd0;   1: op = 5'd2;   2: op = 5'd3;   3: op = 5'd4;
        4: op = 5'd5;   5: op = 5'd6;   6: op = 5'd12;  7: op = 5'd13;
        8: op = 5'd14;  9: op = 5'd26;
        default: begin
          op = 5'($urandom);
          if (op == 5'd27) op = 5'd31;
        end
      endcase
      run_instr(mk(op), -1);
    end

    run_instr(mk(5'b11011), -1);
    #2 clr = 1'b0;
    #1 chk("halt_clr_zero", obs, 128'h0);
    @(negedge clock) clr = 1'b1;
    run_instr(mk(5'b00011), -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port `clock`, input, 1 bit: sole clock; all state changes occur on its rising edge.
REQ-002 SHALL have port `clr`, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port `IR`, input, 32 bits: current instruction register contents from the datapath.
REQ-004 SHALL have port `enc_input`, output, 32 bits: one-hot bus-source select. Bit indices: Zlow 19, PC 20, MDR 22, C 25.
REQ-005 SHALL have port `reg_enable`, output, 32 bits: register load enables. Bit indices: Zlow 19, PC 20, IR 21, MDR 22, MAR 23, Y 24.
REQ-006 SHALL have these 1-bit outputs: `read` (MDR from memory), `write` (memory write), `incPC`, `Rin`, `Rout`, `BAout`.
REQ-007 SHALL have outputs `Gra`, `Grb`, `Grc`, 4 bits each: register number for the general-register select.
REQ-008 SHALL have output `ALU_Sel`, 6 bits: ALU operation code.
REQ-009 SHALL have output `run`, 1 bit: high unless halted or in reset.

Function
REQ-010 SHALL be a Moore FSM with states RST, T0..T7 and HALT; outputs SHALL decode from state plus IR; one step per clock.
REQ-011 SHALL decode IR as: opcode = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
REQ-012 SHALL use these opcodes: LD 00000, ST 00010, ADD 00011, SUB 00100, AND 00101, OR 00110, ADDI 01100, ANDI 01101, ORI 01110, NOP 11010, HALT 11011.
REQ-013 SHALL treat any other opcode as NOP.
REQ-014 SHALL drive, for ALU ops, ALU_Sel = {0, opcode}; ADDI/ANDI/ORI SHALL use the ADD/AND/OR code; LD/ST address add SHALL use the ADD code (6'd3).
REQ-015 Fetch: T0 SHALL assert enc[PC], en[MAR], incPC; T1 SHALL assert read, en[MDR]; T2 SHALL assert enc[MDR], en[IR].
REQ-016 R-type T3 SHALL assert Grb=Rb, Rout, en[Y]; T4 SHALL assert Grc=Rc, Rout, ALU_Sel, en[Zlow]; T5 SHALL assert enc[Zlow], Gra=Ra, Rin; then go to T0.
REQ-017 I-type SHALL match R-type except T4 asserts enc[C] instead of Grc/Rout.
REQ-018 LD T3 SHALL assert Grb=Rb, BAout, en[Y]; T4 SHALL assert enc[C], ADD, en[Zlow]; T5 SHALL assert enc[Zlow], en[MAR]; T6 SHALL assert read, en[MDR]; T7 SHALL assert enc[MDR], Gra=Ra, Rin; then go to T0.
REQ-019 ST T3-T5 SHALL match LD; T6 SHALL assert Gra=Ra, Rout, en[MDR] (read=0); T7 SHALL assert write; then go to T0.
REQ-020 NOP T3 SHALL assert no signals, then go to T0; HALT T3 SHALL go to HALT.
REQ-021 HALT SHALL hold all outputs at 0 and run=0 until clr is asserted.
REQ-022 Instruction latency SHALL be R/I 6 cycles, LD/ST 8, NOP 4.
REQ-023 Gra/Grb/Grc SHALL be 0 in any step not listed above; at most one enc_input bit SHALL be set in any state.
REQ-024 IR SHALL be sampled only in T3..T7; IR changes during T0..T2 SHALL have no effect.

Reset
REQ-025 clr low SHALL force state RST immediately, including mid-instruction, and drive all outputs to 0 and run=0.
REQ-026 The first rising clock edge with clr high SHALL move RST to T0.

Structure
REQ-027 Package cpu_pkg SHALL hold the opcodes, enc/reg bit indices, ALU codes and the state enumeration.
REQ-028 Sub-module ir_decoder SHALL map opcode to instruction class {RTYPE, ITYPE, LD, ST, NOP, HALT}.

Verification
REQ-029 Release clr; IR=0x19A28000 (add R3,R4,R5) -> T0..T5 in 6 cycles; T3 Grb=4; T4 Grc=5, ALU_Sel=3; T5 Gra=3, Rin=1, enc[19]=1.
REQ-030 ADDI R2,R1 (IR[31:15]=01100 0010 0001) -> T3 Grb=1, en[24]; T4 enc[25]=1, ALU_Sel=3; T5 Gra=2, Rin; back to T0 after 6 cycles.
REQ-031 LD then ST -> 8 cycles each; T6 read=1 (LD) and write=0; T7 write=1 (ST) only; BAout=1 in T3 only.
REQ-032 IR opcode 11111 -> treated as NOP, back at T0 after 4 cycles; opcode 11011 -> HALT, run=0, state held for 20 clocks.
REQ-033 clr pulsed low during T4 of ADD -> all outputs 0 within the same cycle; T0 resumes on the first edge after release.
REQ-034 Every cycle: popcount(enc_input) <= 1 checker.
